sort_req_scheduler: RTL

SORT_REQ_SCHEDULER -- requirements
Module: sort_req_scheduler

---
 rtl/sort_req_scheduler.sv | 93 +++++++++
 1 files changed

// File: rtl/sort_req_scheduler.sv
// sort_req_scheduler: round-robin arbiter feeding an in-order sorter, tagging each
// vector with its requester id so the sorted result can be routed back.
module sort_req_scheduler #(
  parameter int LOG_INPUT = 3,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int W = (2 ** LOG_INPUT) * DATA_WIDTH,
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1,
  localparam int PW = $clog2(MAX_OUTSTANDING)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_data,
  output logic          req1_ready,
  output logic [W-1:0]  sort_x,
  output logic          sort_x_valid,
  input  logic [W-1:0]  sort_y,
  input  logic          sort_y_valid,
  output logic [W-1:0]  rsp_data,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  output logic [CW-1:0] outstanding,
  output logic          err_orphan
);
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          tag_q [MAX_OUTSTANDING];
  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic          xv_q, xv_d, r0_q, r0_d, r1_q, r1_d, err_q, err_d;
  logic          room, g0, g1, acc0, acc1, acc, pop;
  assign room = rst && (cnt_q < CW'(MAX_OUTSTANDING));
  assign g0 = req0_valid && (!req1_valid || last_q);
  assign g1 = req1_valid && (!req0_valid || !last_q);
  assign req0_ready = g0 && room;
  assign req1_ready = g1 && room;
  assign acc0 = req0_valid && req0_ready;
  assign acc1 = req1_valid && req1_ready;
  assign acc = acc0 || acc1;
  // An empty tag FIFO is exactly a zero count, so orphans never pop.
  assign pop = sort_y_valid && (cnt_q != '0);
  always_comb begin
    last_d = acc ? acc1 : last_q;
    cnt_d = cnt_q + CW'(acc) - CW'(pop);
    wr_d = wr_q + PW'(acc);
    rd_d = rd_q + PW'(pop);
    x_d = acc0 ? req0_data : acc1 ? req1_data : x_q;
    xv_d = acc;
    y_d = pop ? sort_y : y_q;
    r0_d = pop && !tag_q[rd_q];
    r1_d = pop && tag_q[rd_q];
    err_d = err_q || (sort_y_valid && (cnt_q == '0));
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= 1'b1;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      x_q <= '0;
      xv_q <= 1'b0;
      y_q <= '0;
      r0_q <= 1'b0;
      r1_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      last_q <= last_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      x_q <= x_d;
      xv_q <= xv_d;
      y_q <= y_d;
      r0_q <= r0_d;
      r1_q <= r1_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) tag_q[wr_q] <= acc1;
  end
  assign sort_x = x_q;
  assign sort_x_valid = xv_q;
  assign rsp_data = y_q;
  assign rsp0_valid = r0_q;
  assign rsp1_valid = r1_q;
  assign outstanding = cnt_q;
  assign err_orphan = err_q;
endmodule
